// File: rtl/border_reg_ctrl.sv
// border_reg_ctrl
//   Owns display-control registers CTRL1 (0x11) and CTRL2 (0x16). A CPU write
//   is captured, written into a shadow register on the first dot of a CPU
//   half-cycle, committed to the outputs one dot later, then acknowledged.
//   Also keeps the per-frame bad-line enable latch and the registered
//   bad-line condition for the fetch scheduler.
//
// Ports
//   clk_dot4x        system clock (4x dot clock)
//   rst_n            asynchronous active-low reset
//   clk_phi          1 = CPU half-cycle
//   dot_rising       one-clk strobe per dot
//   cycle_num        current raster cycle
//   raster_line      current raster line
//   wr_req/addr/data CPU write request (held until wr_ack), address, data
//   wr_ack           one-clk write acknowledge
//   rd_addr/rd_data  combinational readback of the shadow registers
//   ecm..yscroll     committed CTRL1 fields
//   res..xscroll     committed CTRL2 fields
//   allow_bad_lines  per-frame bad-line enable
//   bad_line         registered bad-line condition
module border_reg_ctrl #(
  parameter logic [5:0] REG_CTRL1 = 6'h11,
  parameter logic [5:0] REG_CTRL2 = 6'h16,
  parameter logic [8:0] BL_FIRST  = 9'h030,
  parameter logic [8:0] BL_LAST   = 9'h0F7
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       clk_phi,
  input  logic       dot_rising,
  input  logic [6:0] cycle_num,
  input  logic [8:0] raster_line,
  input  logic       wr_req,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       ecm,
  output logic       bmm,
  output logic       den,
  output logic       rsel,
  output logic [2:0] yscroll,
  output logic       res,
  output logic       mcm,
  output logic       csel,
  output logic [2:0] xscroll,
  output logic       allow_bad_lines,
  output logic       bad_line
);

  typedef enum logic [1:0] {IDLE, LATCH, COMMIT, ACK} state_t;

  state_t     state_reg, state_next;
  logic [5:0] hold_addr_reg;
  logic [7:0] hold_data_reg;
  logic [7:0] ctrl1_reg;      // shadow; bit 7 kept only for readback
  logic [5:0] ctrl2_reg;      // shadow; bits 7:6 read back as 1
  logic [6:0] out1_reg;       // committed CTRL1[6:0]
  logic [5:0] out2_reg;       // committed CTRL2[5:0]
  logic       allow_reg;
  logic       bad_line_reg;
  logic       latch_fire;
  logic       commit_fire;
  logic       bad_line_next;

  assign latch_fire  = (state_reg == LATCH)  && dot_rising && clk_phi;
  assign commit_fire = (state_reg == COMMIT) && dot_rising;

  // State register
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wr_req) state_next = LATCH;
      LATCH:   if (dot_rising && clk_phi) state_next = COMMIT;
      COMMIT:  if (dot_rising) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wr_ack = (state_reg == ACK);
  end

  // Holding, shadow and committed registers
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_reg <= 6'h00;
      hold_data_reg <= 8'h00;
      ctrl1_reg     <= 8'h1B;
      ctrl2_reg     <= 6'h08;
      out1_reg      <= 7'h1B;
      out2_reg      <= 6'h08;
    end else begin
      if ((state_reg == IDLE) && wr_req) begin
        hold_addr_reg <= wr_addr;
        hold_data_reg <= wr_data;
      end
      // Unknown addresses fall through here and still complete the handshake.
      if (latch_fire) begin
        if (hold_addr_reg == REG_CTRL1)      ctrl1_reg <= hold_data_reg;
        else if (hold_addr_reg == REG_CTRL2) ctrl2_reg <= hold_data_reg[5:0];
      end
      if (commit_fire) begin
        out1_reg <= ctrl1_reg[6:0];
        out2_reg <= ctrl2_reg;
      end
    end
  end

  // Readback shows the shadows, so a write is visible before it commits.
  always_comb begin
    case (rd_addr)
      REG_CTRL1: rd_data = ctrl1_reg;
      REG_CTRL2: rd_data = {2'b11, ctrl2_reg};
      default:   rd_data = 8'hFF;
    endcase
  end

  assign bad_line_next = allow_reg
                      && (raster_line >= BL_FIRST) && (raster_line <= BL_LAST)
                      && (raster_line[2:0] == out1_reg[2:0]);

  // Frame-start clear takes priority over the DEN sample on line BL_FIRST.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      allow_reg    <= 1'b0;
      bad_line_reg <= 1'b0;
    end else begin
      if (dot_rising && clk_phi) begin
        if ((raster_line == 9'd0) && (cycle_num == 7'd0))
          allow_reg <= 1'b0;
        else if ((raster_line == BL_FIRST) && out1_reg[4])
          allow_reg <= 1'b1;
      end
      if (dot_rising) bad_line_reg <= bad_line_next;
    end
  end

  assign ecm             = out1_reg[6];
  assign bmm             = out1_reg[5];
  assign den             = out1_reg[4];
  assign rsel            = out1_reg[3];
  assign yscroll         = out1_reg[2:0];
  assign res             = out2_reg[5];
  assign mcm             = out2_reg[4];
  assign csel            = out2_reg[3];
  assign xscroll         = out2_reg[2:0];
  assign allow_bad_lines = allow_reg;
  assign bad_line        = bad_line_reg;

endmodule

// File: tb/tb_border_reg_ctrl.sv
// tb_border_reg_ctrl
//   Randomized bench for border_reg_ctrl. A raster generator runs a compact
//   frame (263 lines x 32 clocks, a dot every 4 clocks, alternating CPU and
//   VIC half-cycles). A transaction-level reference model predicts every
//   output and the readback each clock; directed sequences cover reset,
//   write timing, the bad-line rules and reset during a pending write.
module tb_border_reg_ctrl;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic       clk_phi;
  logic       dot_rising;
  logic [6:0] cycle_num;
  logic [8:0] raster_line;
  logic       wr_req;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       ecm, bmm, den, rsel, res, mcm, csel;
  logic [2:0] yscroll, xscroll;
  logic       allow_bad_lines, bad_line;

  always #5 clk_dot4x = ~clk_dot4x;

  border_reg_ctrl dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .clk_phi(clk_phi),
    .dot_rising(dot_rising), .cycle_num(cycle_num), .raster_line(raster_line),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .ecm(ecm), .bmm(bmm), .den(den), .rsel(rsel), .yscroll(yscroll),
    .res(res), .mcm(mcm), .csel(csel), .xscroll(xscroll),
    .allow_bad_lines(allow_bad_lines), .bad_line(bad_line)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_c1, m_c2;        // shadow registers as the CPU sees them
  logic [7:0] m_o1, m_o2;        // values visible to the video logic
  logic       m_allow, m_bad, m_ack;
  logic       p_busy, p_latched; // a write is in flight / already in the shadow
  logic [5:0] p_addr;
  logic [7:0] p_data;

  task automatic model_reset();
    m_c1 = 8'h1B; m_c2 = 8'h08; m_o1 = 8'h1B; m_o2 = 8'h08;
    m_allow = 1'b0; m_bad = 1'b0; m_ack = 1'b0;
    p_busy = 1'b0; p_latched = 1'b0;
  endtask

  // Applies the rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic nb, na;
    nb = m_bad;
    na = m_allow;
    if (dot_rising)
      nb = m_allow && (raster_line >= 9'h030) && (raster_line <= 9'h0F7)
           && (raster_line % 8 == {6'd0, m_o1[2:0]});
    if (dot_rising && clk_phi) begin
      if (raster_line == 0 && cycle_num == 0) na = 1'b0;
      else if (raster_line == 9'h030 && m_o1[4]) na = 1'b1;
    end
    if (m_ack) begin
      m_ack = 1'b0;
    end else if (p_busy && p_latched) begin
      if (dot_rising) begin
        m_o1 = m_c1; m_o2 = m_c2; m_ack = 1'b1; p_busy = 1'b0;
      end
    end else if (p_busy) begin
      if (dot_rising && clk_phi) begin
        if (p_addr == 6'h11) m_c1 = p_data;
        else if (p_addr == 6'h16) m_c2 = p_data;
        p_latched = 1'b1;
      end
    end else if (wr_req) begin
      p_busy = 1'b1; p_latched = 1'b0; p_addr = wr_addr; p_data = wr_data;
    end
    m_bad = nb;
    m_allow = na;
  endtask

  function automatic logic [16:0] model_vec();
    return {m_o1[6], m_o1[5], m_o1[4], m_o1[3], m_o1[2:0],
            m_o2[5], m_o2[4], m_o2[3], m_o2[2:0], m_allow, m_bad, m_ack};
  endfunction

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    if (a == 6'h11) return m_c1;
    if (a == 6'h16) return {2'b11, m_c2[5:0]};
    return 8'hFF;
  endfunction

  function automatic logic [16:0] dut_vec();
    return {ecm, bmm, den, rsel, yscroll, res, mcm, csel, xscroll,
            allow_bad_lines, bad_line, wr_ack};
  endfunction

  // ---------------- raster generator / clock step ----------------
  int  line_pos = 0;
  int  line = 0;
  int  cyc = 0;
  int  bad_rises = 0;
  bit  prev_bad = 0;
  bit  allow_seen = 0;
  bit  rd_fixed = 0;

  task automatic apply_gen();
    raster_line = line[8:0];
    cycle_num   = 7'(line_pos / 8);
    clk_phi     = (line_pos % 8) < 4;
    dot_rising  = (line_pos % 4) == 0;
  endtask

  task automatic step();
    int r;
    @(posedge clk_dot4x);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    cyc++;
    check_eq("outs", 32'(dut_vec()), 32'(model_vec()));
    check_eq("rdback", 32'(rd_data), 32'(model_rd(rd_addr)));
    if (bad_line && !prev_bad) bad_rises++;
    prev_bad = bad_line;
    if (allow_bad_lines) allow_seen = 1;
    line_pos++;
    if (line_pos == 32) begin
      line_pos = 0;
      line++;
      if (line == 263) line = 0;
    end
    apply_gen();
    if (!rd_fixed) begin
      r = $urandom_range(0, 3);
      rd_addr = (r == 0) ? 6'h11 : (r == 1) ? 6'h16 : 6'($urandom);
    end
  endtask

  task automatic run_to(input int l);
    int n = 0;
    while (!(line == l && line_pos == 0) && n < 20000) begin
      step();
      n++;
    end
    check_eq("run_to_bound", 32'(n < 20000), 32'd1);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    int  n = 0;
    bit  got = 0;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    while (!got && n < 300) begin
      step();
      n++;
      if (wr_ack) got = 1;
    end
    wr_req = 1'b0;
    check_eq("ack_seen", 32'(got), 32'd1);
    step();
    check_eq("ack_width", 32'(wr_ack), 32'd0);
  endtask

  localparam logic [16:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 3'd3,
                                       1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};

  initial begin
    int t_sh, t_cs, acks, n, r;
    rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = 6'h16;
    apply_gen();
    model_reset();
    repeat (3) step();
    #1 rst_n = 1'b1;

    // Reset values
    check_eq("rst_den", 32'(den), 32'd1);
    check_eq("rst_rsel", 32'(rsel), 32'd1);
    check_eq("rst_csel", 32'(csel), 32'd1);
    check_eq("rst_yscroll", 32'(yscroll), 32'd3);
    check_eq("rst_xscroll", 32'(xscroll), 32'd0);
    check_eq("rst_allow", 32'(allow_bad_lines), 32'd0);
    rd_addr = 6'h16;
    #1 check_eq("rst_rd16", 32'(rd_data), 32'hC8);

    // CTRL2 write requested in the VIC half-cycle; commit one dot after latch
    n = 0;
    while (clk_phi && n < 16) begin step(); n++; end
    rd_fixed = 1; rd_addr = 6'h16;
    wr_addr = 6'h16; wr_data = 8'h00; wr_req = 1'b1;
    t_sh = -1; t_cs = -1; acks = 0;
    repeat (60) begin
      step();
      if (rd_data == 8'hC0 && t_sh < 0) t_sh = cyc;
      if (!csel && t_cs < 0) t_cs = cyc;
      if (wr_ack) begin acks++; wr_req = 1'b0; end
    end
    check_eq("w16_acks", 32'(acks), 32'd1);
    check_eq("w16_shadow_seen", 32'(t_sh > 0), 32'd1);
    check_eq("w16_commit_delay", 32'(t_cs - t_sh), 32'd4);
    check_eq("w16_csel", 32'(csel), 32'd0);
    check_eq("w16_rd", 32'(rd_data), 32'hC0);
    rd_fixed = 0;

    // Bad lines with den=1, yscroll=3
    bad_rises = 0;
    run_to(9'h031);
    check_eq("bl_allow_set", 32'(allow_bad_lines), 32'd1);
    run_to(9'h033); step();
    check_eq("bl_line33", 32'(bad_line), 32'd1);
    run_to(9'h0FB); step();
    check_eq("bl_lineFB", 32'(bad_line), 32'd0);
    run_to(9'h100);
    check_eq("bl_rises", 32'(bad_rises), 32'd25);
    run_to(0); step();
    check_eq("bl_allow_clr", 32'(allow_bad_lines), 32'd0);

    // den=0 before line 0x30 suppresses the frame; late den=1 is ignored
    do_write(6'h11, 8'h0B);
    check_eq("den_off", 32'(den), 32'd0);
    bad_rises = 0; allow_seen = 0;
    run_to(9'h031);
    do_write(6'h11, 8'h1B);
    run_to(0); step();
    check_eq("nobl_rises", 32'(bad_rises), 32'd0);
    check_eq("nobl_allow", 32'(allow_seen), 32'd0);
    run_to(9'h031);
    check_eq("nextframe_allow", 32'(allow_bad_lines), 32'd1);

    // Unknown address: handshake only
    do_write(6'h20, 8'h5A);
    rd_fixed = 1;
    rd_addr = 6'h20; #1 check_eq("rd20", 32'(rd_data), 32'hFF);
    rd_addr = 6'h11; #1 check_eq("rd11_kept", 32'(rd_data), 32'h1B);
    rd_addr = 6'h16; #1 check_eq("rd16_kept", 32'(rd_data), 32'hC0);
    rd_fixed = 0;
    check_eq("w20_csel", 32'(csel), 32'd0);

    // Reset while the write waits to commit
    wr_addr = 6'h16; wr_data = 8'h0F; wr_req = 1'b1;
    n = 0;
    while (!p_latched && n < 100) begin step(); n++; end
    check_eq("commit_reached", 32'(p_latched), 32'd1);
    #2 rst_n = 1'b0; wr_req = 1'b0;
    #1 model_reset();
    check_eq("rst_async_outs", 32'(dut_vec()), 32'(RESET_VEC));
    rd_fixed = 1; rd_addr = 6'h16;
    #1 check_eq("rst_async_rd16", 32'(rd_data), 32'hC8);
    rd_fixed = 0;
    acks = 0;
    repeat (3) begin step(); if (wr_ack) acks++; end
    #1 rst_n = 1'b1;
    repeat (20) begin step(); if (wr_ack) acks++; end
    check_eq("rst_no_ack", 32'(acks), 32'd0);
    do_write(6'h16, 8'h08);

    // Randomized writes across frames
    repeat (60) begin
      repeat ($urandom_range(10, 300)) step();
      r = $urandom_range(0, 9);
      do_write((r < 4) ? 6'h11 : (r < 8) ? 6'h16 : 6'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/border_reg_ctrl.md
Name: border_reg_ctrl

Overview:
- Owns the display-control registers 0x11 and 0x16 and sequences CPU writes into them at video-correct timing.
- Drives rsel, csel and den into the border logic, and yscroll and xscroll into the fetch and pixel logic.
- Maintains the per-frame bad-line enable latch and the bad_line condition consumed by the fetch scheduler.
- Sits between the CPU bus interface and the border, sequencer and pixel pipelines.

Parameters:
- REG_CTRL1, 6'h11, register address carrying ECM/BMM/DEN/RSEL/YSCROLL.
- REG_CTRL2, 6'h16, register address carrying RES/MCM/CSEL/XSCROLL.
- BL_FIRST, 9'h030, first raster line eligible for bad lines and for the DEN sample.
- BL_LAST, 9'h0F7, last raster line eligible for bad lines.

Ports:
- clk_dot4x  in  1  system clock (4x dot clock).
- rst_n  in  1  reset; asynchronous assert, active-low.
- clk_phi  in  1  CPU phase indicator; 1 = CPU half-cycle.
- dot_rising  in  1  one-clk strobe marking each dot.
- cycle_num  in  7  current raster cycle, 0..62 or 0..64.
- raster_line  in  9  current raster line.
- wr_req  in  1  CPU write request; held until wr_ack.
- wr_addr  in  6  register address.
- wr_data  in  8  write data.
- wr_ack  out  1  one-clk acknowledge.
- rd_addr  in  6  readback address.
- rd_data  out  8  readback data, combinational.
- ecm, bmm, den, rsel  out  1 each  committed CTRL1 bits.
- yscroll  out  3  committed CTRL1[2:0].
- res, mcm, csel  out  1 each  committed CTRL2 bits.
- xscroll  out  3  committed CTRL2[2:0].
- allow_bad_lines  out  1  per-frame bad-line enable.
- bad_line  out  1  registered bad-line condition.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - ctrl1 shadow = 8'h1B: den=1, rsel=1, yscroll=3, ecm=bmm=0.
  - ctrl2 shadow = 8'h08: csel=1, xscroll=0, res=mcm=0.
  - All outputs take their shadow-derived values.
  - allow_bad_lines=0, bad_line=0, wr_ack=0.
- FSM states are IDLE -> LATCH -> COMMIT -> ACK -> IDLE.
- IDLE: on wr_req=1, capture wr_addr and wr_data into holding registers, then go to LATCH.
- LATCH:
  - Wait for a clock with dot_rising=1 and clk_phi=1.
  - On that clock, write the holding data into the matching shadow and go to COMMIT.
  - An address matching neither register writes nothing but still completes the sequence.
- COMMIT:
  - On the next dot_rising, copy the shadows to the output registers and go to ACK.
  - Border, sequencer and pixel logic therefore see a new rsel, csel or den exactly one dot after the shadow write.
- ACK: assert wr_ack for exactly one clk, then return to IDLE.
- Write rules:
  - wr_req must be low for at least one clk before the next request.
  - wr_req seen high in IDLE immediately after ACK is treated as a new write.
- Reset mid-write: the pending write is discarded and the shadows return to their reset values.
- Readback:
  - REG_CTRL1 returns ctrl1 shadow. Bit 7 is stored but not used here.
  - REG_CTRL2 returns {2'b11, ctrl2[5:0]}. Bits 7:6 always read 1.
  - Any other address returns 8'hFF.
  - Readback reflects the shadow immediately after the LATCH write, before COMMIT.
- allow_bad_lines, evaluated only on dot_rising with clk_phi=1:
  - Cleared when raster_line==0 and cycle_num==0.
  - Set when raster_line==BL_FIRST and the committed den==1, in any cycle.
  - If both conditions hold on the same clock, clear wins.
  - Once set, it stays set for the rest of the frame even if den later drops.
- bad_line:
  - Registered on every dot_rising.
  - Value = allow_bad_lines && raster_line in [BL_FIRST, BL_LAST] && raster_line[2:0]==yscroll.
  - Uses committed outputs, so a yscroll write mid-line takes effect one dot after COMMIT.
- Arithmetic: all compares are unsigned 9-bit on raster_line and 3-bit on the scroll fields. No wrap handling is needed.

Test Plan:
- Reset -> den=1, rsel=1, csel=1, yscroll=3, xscroll=0; rd_data at 0x16 = 8'hC8; allow_bad_lines=0.
- Write 0x16 <= 8'h00 with clk_phi low at the request -> no commit until clk_phi=1 and dot_rising. Then csel=0 exactly one dot after the shadow write, wr_ack pulses for one clk, and rd_data at 0x16 = 8'hC0.
- den=1 at raster 0x030 -> allow_bad_lines=1. With yscroll=3, bad_line=1 on lines 0x033, 0x03B, ... 0x0F3, and 0 on 0x0FB. allow_bad_lines clears at line 0, cycle 0.
- Write 0x11 <= 8'h0B (den=0) before line 0x030 -> allow_bad_lines stays 0 and no bad_line is asserted all frame. Setting den=1 again at line 0x031 has no effect until the next frame.
- Write to address 0x20 -> wr_ack pulses and no shadow or output changes. rd_addr=0x20 returns 8'hFF.
- Deassert rst_n while in COMMIT -> all outputs return to reset values asynchronously, no wr_ack occurs, and the FSM is in IDLE after release.
